// File: rtl/vedic_mac_accum.sv
// vedic_mac_accum: accumulates a programmed number of unsigned products
// arriving over a valid/ready handshake. It then holds the total on
// acc_out/acc_valid until the consumer acknowledges it.
//
// Build option: define VEDIC_MAC_SATURATE_EN to make the accumulator clamp
// to all-ones on carry-out. Without it, the sum wraps modulo 2^ACC_W.
// In both modes, ovf is a sticky flag for the current accumulation.
module vedic_mac_accum #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ack,
  output logic              busy,
  output logic              ovf
);

  // Zero-extension width that lifts a product to the (ACC_W+1)-bit adder.
  localparam int EXT_W = ACC_W + 1 - PROD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               ready_q, valid_q, busy_q;
  logic               xfer;
  logic [ACC_W:0]     sum;

  // The extra top bit of sum is the carry-out, which flags overflow.
  assign sum  = {1'b0, acc_q} + {{EXT_W{1'b0}}, prod_in};
  assign xfer = prod_valid & ready_q;

  // State, datapath and Moore output registers.
  // The outputs are registered from the next state, so they change exactly
  // when the state does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ready_q <= (state_d == ACC);
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d == ACC) || (state_d == DONE);
    end
  end

  // Next-state logic and accumulation.
  // acc and ovf are only cleared by a new start, so the last result stays
  // readable in IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = len;
          if (len != '0) begin
            state_d = ACC;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACC: begin
        if (xfer) begin
          cnt_d = cnt_q - LEN_W'(1);
          ovf_d = ovf_q | sum[ACC_W];
`ifdef VEDIC_MAC_SATURATE_EN
          // Once clamped, any further non-zero add carries out again,
          // so the accumulator stays pinned at all-ones.
          if (sum[ACC_W]) begin
            acc_d = {ACC_W{1'b1}};
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
`else
          acc_d = sum[ACC_W-1:0];
`endif
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Any start arriving in this cycle is deliberately not latched.
        if (acc_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign prod_ready = ready_q;
  assign acc_valid  = valid_q;
  assign busy       = busy_q;
  assign acc_out    = acc_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_vedic_mac_accum.sv
// Scoreboard bench for vedic_mac_accum (ACC_W=33 so the wrap case is reachable).
module tb_vedic_mac_accum;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 33;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [PROD_W-1:0] prod_in = '0;
  logic              prod_valid = 1'b0;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ack = 1'b0;
  logic              busy;
  logic              ovf;

  vedic_mac_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ack(acc_ack),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare when a result appears, then check it stays stable.
  logic             prev_valid = 1'b0;
  logic [ACC_W-1:0] held = '0;
  always @(negedge clk) begin
    if (acc_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, expected none", acc_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result acc_out=0x%0h ovf=%0b (expected 0x%0h ovf=%0b)", acc_out, ovf, e.acc, e.ovf);
        check("result_acc", 64'(acc_out), 64'(e.acc));
        check("result_ovf", 64'(ovf), 64'(e.ovf));
      end
      held = acc_out;
    end else if (acc_valid) begin
      check("held_stable", 64'(acc_out), 64'(held));
    end
    prev_valid = acc_valid;
  end

  task automatic push(input logic [ACC_W-1:0] a, input logic o);
    exp_t e;
    e.acc = a;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one product, wait for the handshake, and return at the negedge after the transfer.
  task automatic send(input logic [PROD_W-1:0] p, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    prod_valid = 1'b1;
    prod_in    = p;
    n = 0;
    while (!prod_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!prod_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got prod_ready=0, expected 1");
    end
    @(negedge clk);
    prod_valid = 1'b0;
    $display("sent product 0x%0h", p);
  endtask

  // Hold acc_ack low for 'hold' cycles while the result is held, then acknowledge it.
  task automatic ack(input int hold);
    for (int i = 0; i < hold; i++) begin
      check("valid_while_waiting", 64'(acc_valid), 64'd1);
      @(negedge clk);
    end
    check("valid_before_ack", 64'(acc_valid), 64'd1);
    acc_ack = 1'b1;
    @(negedge clk);
    acc_ack = 1'b0;
    check("valid_after_ack", 64'(acc_valid), 64'd0);
    check("busy_after_ack", 64'(busy), 64'd0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_acc_out", 64'(acc_out), 64'd0);
    check("rst_valid", 64'(acc_valid), 64'd0);
    check("rst_ready", 64'(prod_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    reset = 1'b1;

    // 1: three back-to-back products; the result appears right after the last transfer.
    push(33'd940, 1'b0);
    do_start(8'd3);
    check("t1_busy", 64'(busy), 64'd1);
    send(32'd40, 0);
    send(32'd225, 0);
    check("t1_not_early", 64'(acc_valid), 64'd0);
    send(32'd675, 0);
    check("t1_latency", 64'(acc_valid), 64'd1);
    ack(1);

    // 2: an empty sum finishes at once and never raises prod_ready.
    push(33'd0, 1'b0);
    prod_valid = 1'b1;
    prod_in    = 32'd12345;
    do_start(8'd0);
    check("t2_valid", 64'(acc_valid), 64'd1);
    check("t2_no_ready", 64'(prod_ready), 64'd0);
    prod_valid = 1'b0;
    ack(0);

    // 3: gaps between products, and the result held for four cycles before the ack.
    push(33'd7731, 1'b0);
    do_start(8'd2);
    send(32'd360, 3);
    send(32'd7371, 3);
    ack(4);
    @(negedge clk);
    check("t3_idle_busy", 64'(busy), 64'd0);
    check("t3_idle_acc_hold", 64'(acc_out), 64'd7731);

    // 4: carry-out of a 33-bit accumulator.
`ifdef VEDIC_MAC_SATURATE_EN
    push(33'h1FFFFFFFF, 1'b1);
`else
    push(33'h0FFFA0003, 1'b1);
`endif
    do_start(8'd3);
    for (int i = 0; i < 3; i++) send(32'hFFFE0001, 0);
    ack(2);
    check("t4_ovf_hold", 64'(ovf), 64'd1);

    // 5: reset asserted mid-accumulation clears everything at once.
    do_start(8'd4);
    check("t5_ovf_cleared", 64'(ovf), 64'd0);
    send(32'd100, 0);
    send(32'd200, 0);
    reset = 1'b0;
    #1;
    check("t5_rst_acc", 64'(acc_out), 64'd0);
    check("t5_rst_ready", 64'(prod_ready), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_valid", 64'(acc_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    push(33'd1460, 1'b0);
    do_start(8'd1);
    send(32'd1460, 0);
    ack(1);

    // 6: start pulsed during ACC and prod_valid during DONE are both ignored.
    push(33'd300, 1'b0);
    do_start(8'd2);
    send(32'd100, 0);
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start = 1'b0;
    send(32'd200, 1);
    prod_valid = 1'b1;
    prod_in    = 32'd999;
    repeat (2) begin
      @(negedge clk);
      check("t6_no_ready_done", 64'(prod_ready), 64'd0);
    end
    prod_valid = 1'b0;
    // start arriving together with the ack is dropped, so the block goes to IDLE and stays there.
    start   = 1'b1;
    len     = 8'd3;
    acc_ack = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    acc_ack = 1'b0;
    check("t6_ack_valid", 64'(acc_valid), 64'd0);
    @(negedge clk);
    check("t6_start_ignored", 64'(busy), 64'd0);
    check("t6_acc_hold", 64'(acc_out), 64'd300);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
